// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared constants and helpers for operand-select pipeline stages
package cpu_pipe_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_ONE   = 2'd1;
    localparam logic [1:0] LVL_FULL  = 2'd2;

    // Smallest r with 2**r >= v; used to validate select widths at elaboration.
    function automatic int clog2_int(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// rtl/skid_buf.sv - two-entry registered skid buffer with flush and occupancy output
module skid_buf
    import cpu_pipe_pkg::*;
#(
    parameter int DW = DEF_WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    level
);

    logic          r_main_valid;
    logic [DW-1:0] r_main_data;
    logic          r_skid_valid;
    logic [DW-1:0] r_skid_data;
    logic          w_accept;
    logic          w_pop;

    // Ready depends only on the skid register, so out_ready never reaches in_ready.
    assign in_ready  = !r_skid_valid;
    assign w_accept  = in_valid && !r_skid_valid;
    assign w_pop     = r_main_valid && out_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (!r_main_valid) begin
            if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
            end
        end else if (!r_skid_valid) begin
            if (w_accept && w_pop) begin
                r_main_data <= in_data;
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
            end else if (w_pop) begin
                r_main_valid <= 1'b0;
            end
        end else if (w_pop) begin
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end
    end

    always_comb begin
        level = LVL_EMPTY;
        if (r_main_valid && r_skid_valid) begin
            level = LVL_FULL;
        end else if (r_main_valid || r_skid_valid) begin
            level = LVL_ONE;
        end
    end

endmodule

// File: rtl/mux_pipe_n.sv
// rtl/mux_pipe_n.sv - N-way operand select with out-of-range flag feeding a skid buffer
module mux_pipe_n
    import cpu_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = 3,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_oob,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         level
);

    if (N < 2 || SEL_W < clog2_int(N)) begin : g_bad_params
        $error("mux_pipe_n: need N >= 2 and 2**SEL_W >= N");
    end

    logic [WIDTH-1:0] w_sel_data;
    logic             w_oob;
    logic [WIDTH:0]   w_buf_out;

    // Out-of-range selects fall back to the last input and are flagged.
    always_comb begin
        w_sel_data = data_in[(N-1)*WIDTH +: WIDTH];
        w_oob      = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_data = data_in[k*WIDTH +: WIDTH];
                w_oob      = 1'b0;
            end
        end
    end

    skid_buf #(
        .DW(WIDTH + 1)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({w_oob, w_sel_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_buf_out),
        .level     (level)
    );

    assign out_oob  = w_buf_out[WIDTH];
    assign out_data = w_buf_out[WIDTH-1:0];

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb/tb_mux_pipe_n.sv - self-checking bench for mux_pipe_n against a queue model
module tb_mux_pipe_n;

    localparam int W  = 32;
    localparam int NI = 3;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NI*W-1:0] data_in = '0;
    logic [SW-1:0]   sel = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic [W-1:0]    out_data;
    logic            out_oob;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [1:0]      level;

    int checks = 0;
    int errors = 0;

    logic [W:0] q[$];
    logic       prev_valid = 1'b0;
    logic [W:0] prev_word  = '0;

    localparam logic [NI*W-1:0] BASE = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};

    mux_pipe_n #(.WIDTH(W), .N(NI), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_oob   (out_oob),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Expected entry for a given select: {oob, word}.
    function automatic logic [W:0] pick(input logic [SW-1:0] s, input logic [NI*W-1:0] d);
        int idx;
        idx = (int'(s) < NI) ? int'(s) : NI - 1;
        return {int'(s) >= NI, d[idx*W +: W]};
    endfunction

    always @(posedge clk or posedge rst) begin
        bit acc;
        bit pop;
        if (rst || flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            pop = (q.size() > 0) && out_ready;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(pick(sel, data_in));
        end
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, q.size() != 0);
        chk("level", level, q.size());
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0][W-1:0]);
            chk("out_oob", out_oob, q[0][W]);
        end
        if (prev_valid && out_valid && !out_ready && !flush && !rst)
            chk("held", {out_oob, out_data}, prev_word);
        prev_valid = out_valid;
        prev_word  = {out_oob, out_data};
    end

    task automatic fill_two();
        #1 out_ready = 1'b0; flush = 1'b0; in_valid = 1'b1; data_in = BASE; sel = 2'd0;
        @(negedge clk);
        #1 sel = 2'd1;
        @(negedge clk);
        chk("fill_level", level, 2);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_head", out_data, 32'hAAAA0001);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_oob", out_oob, 0);
        chk("rst_level", level, 0);
        chk("rst_in_ready", in_ready, 1);

        #1 rst = 1'b0; in_valid = 1'b1; sel = 2'd1; data_in = BASE; out_ready = 1'b1;
        @(negedge clk);
        chk("basic_valid", out_valid, 1);
        chk("basic_data", out_data, 32'hBBBB0002);
        chk("basic_oob", out_oob, 0);
        chk("basic_level", level, 1);

        #1 sel = 2'd3;
        @(negedge clk);
        chk("oob_data", out_data, 32'hCCCC0003);
        chk("oob_flag", out_oob, 1);
        chk("oob_level", level, 1);

        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", out_valid, 0);

        fill_two();
        #1 sel = 2'd2;
        repeat (3) begin
            @(negedge clk);
            chk("stall_data", out_data, 32'hAAAA0001);
            chk("stall_level", level, 2);
        end
        #1 in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second", out_data, 32'hBBBB0002);
        chk("bp_level1", level, 1);
        @(negedge clk);
        chk("bp_empty", level, 0);

        for (int i = 0; i < 8; i++) begin
            #1 in_valid = 1'b1; out_ready = 1'b1; sel = SW'(i % 4);
            data_in = {$urandom, $urandom, $urandom};
            @(negedge clk);
            chk("stream_level_le1", level <= 2'd1, 1);
            chk("stream_in_ready", in_ready, 1);
            chk("stream_valid", out_valid, 1);
        end
        #1 in_valid = 1'b0;
        @(negedge clk);

        fill_two();
        #1 flush = 1'b1; in_valid = 1'b1; sel = 2'd2; data_in = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_level", level, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_data", out_data, 0);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_dropped", out_valid, 0);

        fill_two();
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_data", out_data, 0);
        @(negedge clk);
        #1 rst = 1'b0; in_valid = 1'b1; sel = 2'd0; data_in = BASE; out_ready = 1'b1;
        @(negedge clk);
        chk("arst_after_valid", out_valid, 1);
        chk("arst_after_data", out_data, 32'hAAAA0001);

        for (int i = 0; i < 600; i++) begin
            #1;
            rst       = ($urandom_range(99) == 0);
            flush     = ($urandom_range(19) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            sel       = SW'($urandom_range(3));
            data_in   = {$urandom, $urandom, $urandom};
            @(negedge clk);
        end
        #1 rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
